// File: rtl/lmsm_expander.sv
// ---------------------------------------------------------------------------
// lmsm_expander
//   Sits between the IF/ID register and the control decoder. Ordinary
//   instructions pass through a single output register stage. LM (0110) and
//   SM (0111) are expanded into a sequence of single LW (0100) / SW (0101)
//   micro-ops, so the decoder only ever sees opcodes it already handles.
//   Fetch is stalled (in_ready low) while an expansion is in progress.
//
// Ports
//   clk        in   1   clock
//   reset      in   1   synchronous, active-high reset
//   flush      in   1   pipeline flush (redirect); overrides accept/advance
//   in_instr   in   16  instruction from IF/ID: [15:12] op, [11:9] Ra, [7:0] list
//   in_pc      in   16  PC of in_instr
//   in_valid   in   1   in_instr valid
//   in_ready   out  1   expander accepts in_instr this cycle
//   out_instr  out  16  instruction / micro-op to the decoder
//   out_pc     out  16  PC of the originating instruction
//   out_valid  out  1   out_instr valid
//   out_last   out  1   final micro-op of an expansion (1 for pass-through/NOP)
//   out_ready  in   1   decoder consumes out_instr this cycle
//   busy       out  1   expansion in progress
// ---------------------------------------------------------------------------
module lmsm_expander #(
   parameter logic [15:0] NOP_INSTR = 16'hF000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic [15:0] in_instr,
   input  logic [15:0] in_pc,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [15:0] out_instr,
   output logic [15:0] out_pc,
   output logic        out_valid,
   output logic        out_last,
   input  logic        out_ready,
   output logic        busy
);

   localparam logic [3:0] OP_LW = 4'b0100;
   localparam logic [3:0] OP_SW = 4'b0101;
   localparam logic [3:0] OP_LM = 4'b0110;
   localparam logic [3:0] OP_SM = 4'b0111;

   typedef enum logic {IDLE, EXPAND} state_t;

   state_t      state_q, state_d;
   logic [7:0]  mask_q, mask_d;
   logic [7:0]  list_q, list_d;
   logic [2:0]  ra_q, ra_d;
   logic        lm_q, lm_d;
   logic [15:0] out_instr_q, out_instr_d;
   logic [15:0] out_pc_q, out_pc_d;
   logic        out_valid_q, out_valid_d;
   logic        out_last_q, out_last_d;

   // Next register to issue. For LM the base register is deferred to the end
   // so the address base survives until the final load.
   function automatic logic [2:0] pick_next(input logic [7:0] m,
                                            input logic       lm,
                                            input logic [2:0] ra);
      logic [7:0] elig;
      logic [2:0] idx;
      elig = m;
      if (lm) elig[ra] = 1'b0;
      idx = ra;
      for (int i = 7; i >= 0; i--) begin
         if (elig[i]) idx = i[2:0];
      end
      return idx;
   endfunction

   // Rank of bit i within the full list: the memory offset of Ri, which does
   // not depend on issue order.
   function automatic logic [2:0] rank_of(input logic [7:0] l,
                                          input logic [2:0] i);
      logic [2:0] cnt;
      cnt = 3'd0;
      for (int j = 0; j < 8; j++) begin
         if ((j < int'(i)) && l[j]) cnt = cnt + 3'd1;
      end
      return cnt;
   endfunction

   function automatic logic [15:0] make_uop(input logic       lm,
                                            input logic [2:0] i,
                                            input logic [2:0] ra,
                                            input logic [2:0] k);
      return {(lm ? OP_LW : OP_SW), i, ra, 3'b000, k};
   endfunction

   logic       load;
   logic       accept;
   logic       in_is_lmsm;
   logic       src_lm;
   logic [2:0] src_ra;
   logic [7:0] src_mask;
   logic [7:0] src_list;
   logic [2:0] idx;
   logic [7:0] rem;

   always_comb begin
      load       = ~out_valid_q | out_ready;
      in_ready   = (state_q == IDLE) & load & ~flush;
      accept     = in_valid & in_ready;
      in_is_lmsm = (in_instr[15:12] == OP_LM) | (in_instr[15:12] == OP_SM);

      // Micro-op source: fresh instruction while idle, latched state otherwise.
      if (state_q == IDLE) begin
         src_lm   = (in_instr[15:12] == OP_LM);
         src_ra   = in_instr[11:9];
         src_mask = in_instr[7:0];
         src_list = in_instr[7:0];
      end else begin
         src_lm   = lm_q;
         src_ra   = ra_q;
         src_mask = mask_q;
         src_list = list_q;
      end
      idx = pick_next(src_mask, src_lm, src_ra);
      rem = src_mask & ~(8'd1 << idx);

      state_d     = state_q;
      mask_d      = mask_q;
      list_d      = list_q;
      ra_d        = ra_q;
      lm_d        = lm_q;
      out_instr_d = out_instr_q;
      out_pc_d    = out_pc_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;

      if (flush) begin
         state_d     = IDLE;
         mask_d      = 8'd0;
         out_instr_d = 16'd0;
         out_pc_d    = 16'd0;
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end else if (state_q == IDLE) begin
         if (accept) begin
            out_pc_d    = in_pc;
            out_valid_d = 1'b1;
            if (!in_is_lmsm) begin
               out_instr_d = in_instr;
               out_last_d  = 1'b1;
            end else if (in_instr[7:0] == 8'd0) begin
               out_instr_d = NOP_INSTR;
               out_last_d  = 1'b1;
            end else begin
               lm_d        = src_lm;
               ra_d        = src_ra;
               list_d      = src_list;
               out_instr_d = make_uop(src_lm, idx, src_ra, rank_of(src_list, idx));
               out_last_d  = (rem == 8'd0);
               mask_d      = rem;
               state_d     = (rem != 8'd0) ? EXPAND : IDLE;
            end
         end else if (load) begin
            out_valid_d = 1'b0;
         end
      end else if (load) begin
         out_instr_d = make_uop(src_lm, idx, src_ra, rank_of(src_list, idx));
         out_valid_d = 1'b1;
         out_last_d  = (rem == 8'd0);
         mask_d      = rem;
         state_d     = (rem == 8'd0) ? IDLE : EXPAND;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         mask_q      <= 8'd0;
         out_instr_q <= 16'd0;
         out_pc_q    <= 16'd0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         mask_q      <= mask_d;
         out_instr_q <= out_instr_d;
         out_pc_q    <= out_pc_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
      end
      list_q <= list_d;
      ra_q   <= ra_d;
      lm_q   <= lm_d;
   end

   assign out_instr = out_instr_q;
   assign out_pc    = out_pc_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign busy      = (state_q == EXPAND);

endmodule

// File: tb/tb_lmsm_expander.sv
// Scoreboard bench for lmsm_expander: stimulus pushes expected micro-ops,
// a negedge monitor pops and compares every accepted output.
module tb_lmsm_expander;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic [15:0] in_instr;
   logic [15:0] in_pc;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] out_instr;
   logic [15:0] out_pc;
   logic        out_valid;
   logic        out_last;
   logic        out_ready;
   logic        busy;

   int vectors = 0;
   int miscmp  = 0;

   logic [32:0] expq[$];   // {instr, pc, last}

   logic        prev_stall = 1'b0;
   logic [15:0] prev_instr = 16'd0;

   always #5 clk = ~clk;

   lmsm_expander #(.NOP_INSTR(16'hF000)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_instr  (in_instr),
      .in_pc     (in_pc),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_instr (out_instr),
      .out_pc    (out_pc),
      .out_valid (out_valid),
      .out_last  (out_last),
      .out_ready (out_ready),
      .busy      (busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscmp++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic push(input logic [15:0] ins, input logic [15:0] pc, input logic last);
      expq.push_back({ins, pc, last});
   endtask

   // Present an instruction and hold it until accepted; returns at posedge+1.
   task automatic issue(input logic [15:0] ins, input logic [15:0] pc);
      int n;
      n = 0;
      in_instr = ins;
      in_pc    = pc;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check("issue_timeout", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (expq.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      #1;
      check("drain_queue_empty", 32'(expq.size()), 32'd0);
   endtask

   // Monitor: compare every transfer and check stability under backpressure.
   always @(negedge clk) begin
      logic [32:0] e;
      if (reset || flush) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_instr", 32'(out_instr), 32'(prev_instr));
         end
         if (out_valid && out_ready) begin
            if (expq.size() == 0) begin
               check("unexpected_output", 32'(out_instr), 32'hFFFF_FFFF);
            end else begin
               e = expq.pop_front();
               check("sb_instr", 32'(out_instr), 32'(e[32:17]));
               check("sb_pc",    32'(out_pc),    32'(e[16:1]));
               check("sb_last",  32'(out_last),  32'(e[0]));
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_instr = out_instr;
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int lowcnt;
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
      in_instr = 16'd0; in_pc = 16'd0; out_ready = 1'b1;

      // Reset held two cycles
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_busy",      32'(busy),      32'd0);
      check("reset_in_ready",  32'(in_ready),  32'd1);
      check("reset_out_instr", 32'(out_instr), 32'd0);
      @(posedge clk); #1;

      // Pass-through ADD, one-cycle latency
      push(16'h1050, 16'h0010, 1'b1);
      issue(16'h1050, 16'h0010);
      @(negedge clk);
      check("pass_latency_valid", 32'(out_valid), 32'd1);
      check("pass_busy",          32'(busy),      32'd0);
      @(posedge clk); #1;
      drain();

      // SM R1, list 1010_0101: bits 0,2,5,7 ranks 0..3, fetch stalled 3 cycles
      push(16'h5040, 16'h0020, 1'b0);
      push(16'h5441, 16'h0020, 1'b0);
      push(16'h5A42, 16'h0020, 1'b0);
      push(16'h5E43, 16'h0020, 1'b1);
      issue(16'h72A5, 16'h0020);
      lowcnt = 0;
      @(negedge clk);
      while (!in_ready && lowcnt < 20) begin
         lowcnt++;
         @(negedge clk);
      end
      check("sm_stall_cycles", 32'(lowcnt), 32'd3);
      drain();

      // LM R2, list 0000_0110: R1 (k=0) then deferred R2 (k=1)
      push(16'h4280, 16'h0030, 1'b0);
      push(16'h4481, 16'h0030, 1'b1);
      issue(16'h6406, 16'h0030);
      drain();

      // LM R0, list 0000_0011: deferred base has rank 0
      push(16'h4201, 16'h0034, 1'b0);
      push(16'h4000, 16'h0034, 1'b1);
      issue(16'h6003, 16'h0034);
      drain();

      // SM R0, list 0000_0011: no deferral for stores
      push(16'h5000, 16'h0036, 1'b0);
      push(16'h5201, 16'h0036, 1'b1);
      issue(16'h7003, 16'h0036);
      drain();

      // LM R3 with single register R3: one micro-op, never busy
      push(16'h46C0, 16'h0038, 1'b1);
      issue(16'h6608, 16'h0038);
      @(negedge clk);
      check("single_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      drain();

      // Empty LM list -> NOP
      push(16'hF000, 16'h0040, 1'b1);
      issue(16'h6000, 16'h0040);
      @(negedge clk);
      check("nop_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      drain();

      // Backpressure mid-SM: 3 stalled cycles after the first transfer
      push(16'h5040, 16'h0044, 1'b0);
      push(16'h5441, 16'h0044, 1'b0);
      push(16'h5A42, 16'h0044, 1'b0);
      push(16'h5E43, 16'h0044, 1'b1);
      issue(16'h72A5, 16'h0044);
      @(posedge clk); #1;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("bp_instr_held", 32'(out_instr), 32'h5441);
      check("bp_busy",       32'(busy),      32'd1);
      out_ready = 1'b1;
      drain();

      // Flush during EXPAND with the output stalled
      out_ready = 1'b0;
      @(posedge clk); #1;
      issue(16'h72A5, 16'h0050);
      repeat (2) @(posedge clk);
      #1;
      check("fl_pre_instr",    32'(out_instr), 32'h5040);
      check("fl_pre_busy",     32'(busy),      32'd1);
      check("fl_pre_in_ready", 32'(in_ready),  32'd0);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      check("fl_out_valid", 32'(out_valid), 32'd0);
      check("fl_busy",      32'(busy),      32'd0);
      check("fl_in_ready",  32'(in_ready),  32'd1);
      @(posedge clk); #1;

      // Recovery after flush
      out_ready = 1'b1;
      push(16'h1050, 16'h0060, 1'b1);
      issue(16'h1050, 16'h0060);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscmp);
      $finish;
   end

endmodule
